rm_violation_reporter: RTL
==========================

# rm_violation_reporter

Sink for the runtime-monitor rule outputs. Each cycle it captures the per-lane rule-violation vectors from `rm_monitor`, coalesces them into sticky per-lane pending records, and arbitrates round-robin across lanes. Selected records are queued in a small FIFO and presented to the core's exception/trap logic over a valid/ready handshake. For every record queued, it returns a one-cycle release pulse for that lane to the allocator/router side.

## Interface
Parameters:
- NUM_LANES, 7, monitored lanes; must be ≥2.
- NUM_RULES, 10, rule bits per lane; must be ≥2.
- FIFO_DEPTH, 4, report queue entries; power of two, ≥2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous flush of all pending state and the FIFO.
- monitor_i  in  [NUM_LANES][NUM_RULES]  rule-violation flags per lane; level, sampled every cycle.
- lane_reset_i  in  [NUM_LANES]  lane recycled by the router; discards that lane's pending record.
- report_valid_o  out  1  FIFO head valid.
- report_ready_i  in  1  consumer accepts head.
- report_lane_o  out  $clog2(NUM_LANES)  lane index of the head record.
- report_vec_o  out  [NUM_RULES]  coalesced violation vector of the head record.
- report_rule_o  out  $clog2(NUM_RULES)  index of the lowest set bit of report_vec_o.
- lane_release_o  out  [NUM_LANES]  one-cycle pulse, lane's record was queued.
- pending_o  out  [NUM_LANES]  lane has an unqueued record.
- coalesce_cnt_o  out  16  saturating count of coalesce events.

## Operation
- Pending store: per lane, a register `pend_vec[l]` with `pending_o[l] = |pend_vec[l]`.
- Update for each lane, in priority order:
  - flush_i: all cleared.
  - lane_reset_i[l]: `pend_vec <= monitor_i[l]`. The old record is dropped, and new bits in the same cycle are kept.
  - Lane selected for push this cycle: `pend_vec <= monitor_i[l]`.
  - Otherwise: `pend_vec <= pend_vec | monitor_i[l]`.
- Coalesce event: `pending_o[l]` is set and `monitor_i[l] & ~pend_vec[l]` is non-zero, and the lane is neither selected nor reset. Each cycle adds the number of such lanes to coalesce_cnt_o, saturating at 0xFFFF. flush_i does not clear the counter.
- Arbiter:
  - Round-robin pointer `rr_ptr`, reset 0.
  - Candidates are lanes with `pending_o` set and `lane_reset_i` clear.
  - Select the first candidate at or after `rr_ptr`, wrapping NUM_LANES-1 → 0.
  - A push occurs when a candidate exists, flush_i is low, and (FIFO count < FIFO_DEPTH, or a pop occurs this cycle).
  - On push: enqueue {lane, pend_vec}, set `rr_ptr <= sel+1` with wrap, and register a release pulse for `sel`.
  - At most one push per cycle.
- FIFO:
  - Pop when `report_valid_o & report_ready_i`.
  - Push and pop in the same cycle are allowed, including when full or when count is 1.
  - Head outputs come directly from storage (no fall-through). report_valid_o = count≠0.
  - Outputs hold stable while valid&!ready.
- report_rule_o is a priority encoder on report_vec_o. It is 0 when the vector is empty; an empty vector cannot be enqueued.
- flush_i: clears FIFO (count, pointers), all pend_vec, and rr_ptr. A lane_release_o pulse already registered before the flush still fires. The pop handshake is ignored in the flush cycle.

## Timing
- Reset values:
  - All outputs are 0: report_valid_o=0, report_lane_o=0, report_vec_o=0, report_rule_o=0, lane_release_o=0, pending_o=0, coalesce_cnt_o=0.
  - Internal state: rr_ptr=0, FIFO empty.
- Flag latency:
  - monitor_i bit high in cycle N → pending_o high in N+1 → push at end of N+1 (if space) → report_valid_o and lane_release_o pulse in N+2.
  - Minimum flag-to-report latency is 2 cycles.
- Handshake:
  - Pop at end of cycle M → next entry visible in M+1.
  - Sustained throughput is 1 record/cycle with ready held high.
- Back-pressure: a full FIFO blocks pushes. Records stay sticky in pend_vec and no violation bit is lost, unless lane_reset_i discards it.
- Reset asserted mid-operation clears everything asynchronously. The first push is possible in the second cycle after deassertion.

## Test plan
- Single violation: monitor_i[3]=10'b0000100100 for one cycle at N, ready=1 → in N+2: valid=1, lane=3, vec=0x024, rule=2, lane_release_o=7'b0001000 for one cycle; valid=0 in N+3.
- Round-robin: lanes 0, 2 and 5 flag simultaneously, ready=1 → reports in order 0, 2, 5 on consecutive cycles. Then lanes 0 and 5 flag again with rr_ptr=6 → order 0, 5.
- Back-pressure and coalesce, FIFO_DEPTH=4, ready=0:
  - 5 lanes flag → FIFO fills with lanes 0..3, lane 4 stays pending.
  - Lane 4 adds a new bit → coalesce_cnt_o=1.
  - Raise ready → 5 reports; lane 4's vec is the OR of both flags.
- Lane reset: lane 1 pending with vec 0x001 and FIFO full; pulse lane_reset_i[1] with monitor_i[1]=0 → pending_o[1]=0, no lane-1 report, no release pulse for lane 1. Repeat with monitor_i[1]=0x200 in the reset cycle → single report vec=0x200.
- Flush: 3 entries queued, 2 lanes pending, flush_i for one cycle → next cycle valid=0, pending_o=0, coalesce_cnt_o unchanged. A new flag is reported 2 cycles later.
- Saturation and reset: force 70000 coalesce events → coalesce_cnt_o=0xFFFF and holds. Assert rst_ni low mid-stream → all outputs 0 immediately.

Source files
------------

// File: rtl/rm_violation_reporter.sv
// Runtime-monitor violation sink: sticky per-lane records, round-robin
// arbitration into a small report FIFO with per-lane release pulses.
module rm_violation_reporter #(
  parameter int NUM_LANES  = 7,
  parameter int NUM_RULES  = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                flush_i,
  input  logic [NUM_LANES-1:0][NUM_RULES-1:0] monitor_i,
  input  logic [NUM_LANES-1:0]                lane_reset_i,
  output logic                                report_valid_o,
  input  logic                                report_ready_i,
  output logic [$clog2(NUM_LANES)-1:0]        report_lane_o,
  output logic [NUM_RULES-1:0]                report_vec_o,
  output logic [$clog2(NUM_RULES)-1:0]        report_rule_o,
  output logic [NUM_LANES-1:0]                lane_release_o,
  output logic [NUM_LANES-1:0]                pending_o,
  output logic [15:0]                         coalesce_cnt_o
);

  localparam int LW = $clog2(NUM_LANES);
  localparam int RW = $clog2(NUM_RULES);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);
  localparam logic [LW-1:0] LAST_C = LW'(NUM_LANES - 1);

  logic [NUM_LANES-1:0][NUM_RULES-1:0] pend_vec;
  logic [NUM_LANES-1:0] cand;
  logic [NUM_LANES-1:0] sel_oh;
  logic [NUM_LANES-1:0] coal;
  logic [LW-1:0]        rr_ptr;
  logic [LW-1:0]        sel;
  logic                 found;
  logic                 push;
  logic                 pop;
  int                   idx;

  logic [LW-1:0]        mem_lane [FIFO_DEPTH];
  logic [NUM_RULES-1:0] mem_vec  [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [PW:0]          count;
  logic [16:0]          cnt_sum;

  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      pending_o[l] = |pend_vec[l];
    end
  end

  assign cand = pending_o & ~lane_reset_i;

  // First candidate at or after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int i = 0; i < NUM_LANES; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_LANES) idx = idx - NUM_LANES;
      if (!found && cand[idx]) begin
        found = 1'b1;
        sel   = LW'(idx);
      end
    end
  end

  assign report_valid_o = (count != '0);
  assign pop  = report_valid_o & report_ready_i & ~flush_i;
  assign push = found & ~flush_i & ((count < DEPTH_C) | pop);

  always_comb begin
    sel_oh = '0;
    if (push) sel_oh[sel] = 1'b1;
  end

  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      coal[l] = pending_o[l] & ~sel_oh[l] & ~lane_reset_i[l] &
                (|(monitor_i[l] & ~pend_vec[l]));
    end
  end

  always_comb begin
    cnt_sum = {1'b0, coalesce_cnt_o};
    for (int l = 0; l < NUM_LANES; l++) begin
      if (coal[l]) cnt_sum = cnt_sum + 17'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_vec <= '0;
    end else begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (flush_i)              pend_vec[l] <= '0;
        else if (lane_reset_i[l]) pend_vec[l] <= monitor_i[l];
        else if (sel_oh[l])       pend_vec[l] <= monitor_i[l];
        else pend_vec[l] <= pend_vec[l] | monitor_i[l];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr         <= '0;
      lane_release_o <= '0;
      coalesce_cnt_o <= '0;
    end else begin
      lane_release_o <= sel_oh;
      coalesce_cnt_o <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
      if (flush_i)   rr_ptr <= '0;
      else if (push) rr_ptr <= (sel == LAST_C) ? '0 : sel + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int e = 0; e < FIFO_DEPTH; e++) begin
        mem_lane[e] <= '0;
        mem_vec[e]  <= '0;
      end
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_lane[wr_ptr] <= sel;
        mem_vec[wr_ptr]  <= pend_vec[sel];
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign report_lane_o = report_valid_o ? mem_lane[rd_ptr] : '0;
  assign report_vec_o  = report_valid_o ? mem_vec[rd_ptr]  : '0;

  // Lowest set bit wins: scan downward so the last hit is the lowest.
  always_comb begin
    report_rule_o = '0;
    for (int r = NUM_RULES - 1; r >= 0; r--) begin
      if (report_vec_o[r]) report_rule_o = RW'(r);
    end
  end

endmodule
